// File: rtl/lab_fixed_pkg.sv
// Fixed-point formats and the base-2 antilog table shared by the RGB2Lab log/linear stages.
// EXP2_LUT[k] = round(2^(k/64) * 2^15), built at elaboration with exact integer arithmetic.
package lab_fixed_pkg;

    localparam int LOG_INT_W   = 3;
    localparam int LOG_FRAC_W  = 13;
    localparam int LIN_W       = 16;
    localparam int LIN_FRAC_W  = 8;
    localparam int LUT_BITS    = 6;
    localparam int INTERP_BITS = 7;
    localparam int LUT_N       = 1 << LUT_BITS;
    localparam int LUT_W       = 17;
    localparam int DELTA_W     = 11;

    typedef logic [LOG_INT_W+LOG_FRAC_W-1:0] log2_q3_13_t;
    typedef logic [LIN_W-1:0]                lin_q8_8_t;
    typedef logic [LUT_W-1:0]                lut_val_t;
    typedef lut_val_t                        lut_tbl_t [0:LUT_N];

    function automatic logic [63:0] isqrt128(input logic [127:0] n);
        logic [63:0] r;
        logic [63:0] t;
        r = '0;
        for (int b = 63; b >= 0; b--) begin
            t = r | (64'd1 << b);
            if (({64'd0, t} * {64'd0, t}) <= n) r = t;
        end
        return r;
    endfunction

    // 2^(1/64) in Q60 via six nested square roots of 2, then successive powers.
    function automatic lut_tbl_t gen_exp2_lut();
        lut_tbl_t     tbl;
        logic [127:0] s;
        logic [127:0] p;
        s = 128'd1 << 61;
        for (int i = 0; i < LUT_BITS; i++) s = {64'd0, isqrt128(s << 60)};
        p = 128'd1 << 60;
        for (int k = 0; k <= LUT_N; k++) begin
            tbl[k] = lut_val_t'((p + (128'd1 << 44)) >> 45);
            p = (p * s) >> 60;
        end
        return tbl;
    endfunction

    localparam lut_tbl_t EXP2_LUT = gen_exp2_lut();

endpackage

// File: rtl/exp2_lms_if.sv
// Operand/result handshake bundle of the exp2 antilog unit.
interface exp2_lms_if;
    import lab_fixed_pkg::*;

    log2_q3_13_t i_log2;
    logic        i_valid;
    logic        o_ready;
    lin_q8_8_t   o_value;
    logic        o_valid;
    logic        i_ready;

    modport slave  (input  i_log2, i_valid, i_ready, output o_ready, o_value, o_valid);
    modport master (output i_log2, i_valid, i_ready, input  o_ready, o_value, o_valid);
endinterface

// File: rtl/exp2_frac_lut.sv
// Combinational segment lookup: k -> base L[k] and slope L[k+1] - L[k].
module exp2_frac_lut
    import lab_fixed_pkg::*;
(
    input  logic [LUT_BITS-1:0] i_k,
    output lut_val_t            o_base,
    output logic [DELTA_W-1:0]  o_delta
);
    logic [LUT_BITS:0] idx_lo;
    logic [LUT_BITS:0] idx_hi;
    lut_val_t          next_val;

    // Index widened by one bit so k = 63 reaches L[64] instead of wrapping.
    always_comb begin
        idx_lo   = {1'b0, i_k};
        idx_hi   = idx_lo + 7'd1;
        o_base   = EXP2_LUT[idx_lo];
        next_val = EXP2_LUT[idx_hi];
        o_delta  = DELTA_W'(next_val - o_base);
    end
endmodule

// File: rtl/exp2_lms.sv
// 3-stage 3.13 log2 -> 8.8 linear antilog pipeline with a global stall on output backpressure.
module exp2_lms
    import lab_fixed_pkg::*;
(
    input  logic      i_clk,
    input  logic      i_rst,
    exp2_lms_if.slave io
);
    logic                   adv;
    logic                   accept;
    logic [LOG_INT_W-1:0]   op_e;
    logic [LUT_BITS-1:0]    op_k;
    logic [INTERP_BITS-1:0] op_f;
    lut_val_t               lut_base;
    logic [DELTA_W-1:0]     lut_delta;

    logic                   s1_valid_q, s1_valid_d;
    logic [LOG_INT_W-1:0]   s1_e_q,     s1_e_d;
    logic [INTERP_BITS-1:0] s1_f_q,     s1_f_d;
    lut_val_t               s1_base_q,  s1_base_d;
    logic [DELTA_W-1:0]     s1_delta_q, s1_delta_d;
    logic                   s2_valid_q, s2_valid_d;
    logic [LOG_INT_W-1:0]   s2_e_q,     s2_e_d;
    lut_val_t               s2_m_q,     s2_m_d;
    logic                   o_valid_q,  o_valid_d;
    lin_q8_8_t              o_value_q,  o_value_d;

    logic [17:0]            interp_prod;
    logic [DELTA_W-1:0]     interp;
    logic [23:0]            shifted;
    logic [16:0]            rounded;

    exp2_frac_lut u_lut (
        .i_k     (op_k),
        .o_base  (lut_base),
        .o_delta (lut_delta)
    );

    assign {op_e, op_k, op_f} = io.i_log2;
    assign adv        = !o_valid_q || io.i_ready;
    assign io.o_ready = adv && i_rst;
    assign accept     = io.i_valid && io.o_ready;
    assign io.o_valid = o_valid_q;
    assign io.o_value = o_value_q;

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_e_d      = s1_e_q;
        s1_f_d      = s1_f_q;
        s1_base_d   = s1_base_q;
        s1_delta_d  = s1_delta_q;
        s2_valid_d  = s2_valid_q;
        s2_e_d      = s2_e_q;
        s2_m_d      = s2_m_q;
        o_valid_d   = o_valid_q;
        o_value_d   = o_value_q;

        interp_prod = 18'(s1_delta_q) * 18'(s1_f_q);
        interp      = DELTA_W'((interp_prod + 18'd64) >> 7);
        shifted     = 24'(s2_m_q) << s2_e_q;
        rounded     = 17'((shifted + 24'd64) >> 7);

        if (adv) begin
            s1_valid_d = accept;
            s1_e_d     = op_e;
            s1_f_d     = op_f;
            s1_base_d  = lut_base;
            s1_delta_d = lut_delta;
            s2_valid_d = s1_valid_q;
            s2_e_d     = s1_e_q;
            s2_m_d     = s1_base_q + LUT_W'(interp);
            o_valid_d  = s2_valid_q;
            o_value_d  = rounded[16] ? 16'hFFFF : rounded[15:0];
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            s1_valid_q <= 1'b0;
            s1_e_q     <= '0;
            s1_f_q     <= '0;
            s1_base_q  <= '0;
            s1_delta_q <= '0;
            s2_valid_q <= 1'b0;
            s2_e_q     <= '0;
            s2_m_q     <= '0;
            o_valid_q  <= 1'b0;
            o_value_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_e_q     <= s1_e_d;
            s1_f_q     <= s1_f_d;
            s1_base_q  <= s1_base_d;
            s1_delta_q <= s1_delta_d;
            s2_valid_q <= s2_valid_d;
            s2_e_q     <= s2_e_d;
            s2_m_q     <= s2_m_d;
            o_valid_q  <= o_valid_d;
            o_value_q  <= o_value_d;
        end
    end
endmodule
